// File: rtl/dualrail_chan_sink.sv
// dualrail_chan_sink: receives four-phase dual-rail tokens from an asynchronous
// (prsim) domain, synchronizes both rails, decodes complete/neutral/illegal
// codes, returns a registered acknowledge and queues accepted words in a
// first-word-fall-through FIFO.
//
//   state        | meaning
//   -------------+------------------------------------------------------------
//   WAIT_DATA    | in_a=0; waiting for a complete, legal code and FIFO space
//   WAIT_NEUTRAL | in_a=1; token taken, waiting for all rails to return to 0
module dualrail_chan_sink #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_t,
    input  logic [WIDTH-1:0] in_f,
    output logic             in_a,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      tok_count,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic {
        WAIT_DATA    = 1'b0,
        WAIT_NEUTRAL = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] t_meta, t_sync;
    logic [WIDTH-1:0] f_meta, f_sync;

    logic [WIDTH-1:0] bit_valid;
    logic [WIDTH-1:0] bit_illegal;
    logic             any_illegal;
    logic             complete;
    logic             neutral;

    // After reset the synchronizers hold zeros that do not reflect the
    // channel; prime_cnt counts down until the real rails have arrived, and
    // armed is set only once a genuine neutral has been observed.
    logic [1:0]       prime_cnt;
    logic             armed;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    // Two-flop synchronizers on both rails.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_meta <= '0;
            t_sync <= '0;
            f_meta <= '0;
            f_sync <= '0;
        end else begin
            t_meta <= in_t;
            t_sync <= t_meta;
            f_meta <= in_f;
            f_sync <= f_meta;
        end
    end

    assign bit_valid   = t_sync ^ f_sync;
    assign bit_illegal = t_sync & f_sync;
    assign any_illegal = |bit_illegal;
    assign complete    = (&bit_valid) && !any_illegal;
    assign neutral     = ~|(t_sync | f_sync);

    // Arm the receiver after the synchronizers are primed and neutral is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= 2'd2;
            armed     <= 1'b0;
        end else begin
            if (prime_cnt != 2'd0) begin
                prime_cnt <= prime_cnt - 2'd1;
            end
            if ((prime_cnt == 2'd0) && neutral) begin
                armed <= 1'b1;
            end
        end
    end

    // Full uses the registered pointers only, so a same-cycle pop never
    // lets a write into a full FIFO.
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign pop        = out_valid && out_ready;

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_DATA;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and push decode.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            WAIT_DATA: begin
                if (armed && complete && !fifo_full) begin
                    push      = 1'b1;
                    state_nxt = WAIT_NEUTRAL;
                end
            end
            WAIT_NEUTRAL: begin
                if (neutral) begin
                    state_nxt = WAIT_DATA;
                end
            end
            default: state_nxt = WAIT_DATA;
        endcase
    end

    assign in_a = (state == WAIT_NEUTRAL);

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= t_sync;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign out_valid = !fifo_empty;

    // Accepted-token counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            tok_count <= 16'h0000;
        end else if (push) begin
            tok_count <= tok_count + 16'd1;
        end
    end

    // Sticky illegal-code flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (any_illegal) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dualrail_chan_sink.sv
// tb_dualrail_chan_sink: vector table plus hand-written handshake sequences
// for dualrail_chan_sink; accepted words are tracked in a scoreboard queue.
module tb_dualrail_chan_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_t = 4'h0;
    logic [3:0]  in_f = 4'h0;
    logic        in_a;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] tok_count;
    logic        err;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_cnt = 16'h0000;
    logic [3:0]  exp_q [$];

    typedef struct {
        logic [3:0] t;
        logic [3:0] f;
        bit         ack;
    } vec_t;

    vec_t vecs [8];

    dualrail_chan_sink #(.WIDTH(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_t      (in_t),
        .in_f      (in_f),
        .in_a      (in_a),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tok_count (tok_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full four-phase cycle with exact acknowledge latency checks.
    task automatic send(input logic [3:0] t, input logic [3:0] f, input bit ack, input string nm);
        in_t = t;
        in_f = f;
        tick();
        tick();
        check({nm, "_ack_early"}, in_a, 0);
        tick();
        check({nm, "_ack"}, in_a, ack);
        if (ack) begin
            exp_q.push_back(t);
            exp_cnt = exp_cnt + 16'd1;
        end
        check({nm, "_count"}, tok_count, exp_cnt);
        in_t = 4'h0;
        in_f = 4'h0;
        tick();
        tick();
        check({nm, "_ack_hold"}, in_a, ack);
        tick();
        check({nm, "_ack_fall"}, in_a, 0);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        check({nm, "_drained"}, exp_q.size(), 0);
        check({nm, "_empty"}, out_valid, 0);
    endtask

    // Scoreboard: a pop happens on the next rising edge when this holds.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL pop_unexpected: got data %0h, scoreboard empty", out_data);
            end else begin
                check("fifo_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pt, pf, d;

        vecs[0] = '{t: 4'b1010, f: 4'b0101, ack: 1'b1};
        vecs[1] = '{t: 4'b0000, f: 4'b1111, ack: 1'b1};
        vecs[2] = '{t: 4'b1111, f: 4'b0000, ack: 1'b1};
        vecs[3] = '{t: 4'b0110, f: 4'b1001, ack: 1'b1};
        vecs[4] = '{t: 4'b0010, f: 4'b0001, ack: 1'b0};
        vecs[5] = '{t: 4'b1000, f: 4'b0000, ack: 1'b0};
        vecs[6] = '{t: 4'b0001, f: 4'b1110, ack: 1'b1};
        vecs[7] = '{t: 4'b0000, f: 4'b0000, ack: 1'b0};

        // Reset state
        tick();
        tick();
        check("rst_in_a", in_a, 0);
        check("rst_valid", out_valid, 0);
        check("rst_count", tok_count, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        repeat (4) tick();

        // Single token held in the FIFO
        send(4'b1010, 4'b0101, 1'b1, "single");
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 4'hA);
        out_ready = 1'b1;
        drain("single");

        // Vector table
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].t, vecs[i].f, vecs[i].ack, $sformatf("vec%0d", i));
        end
        drain("vec");

        // Partial code building up one bit per cycle
        pt = 4'b1011;
        pf = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            in_t[i] = pt[i];
            in_f[i] = pf[i];
            tick();
            check($sformatf("partial_bit%0d", i), in_a, 0);
        end
        tick();
        check("partial_early", in_a, 0);
        tick();
        check("partial_ack", in_a, 1);
        exp_q.push_back(pt);
        exp_cnt = exp_cnt + 16'd1;
        check("partial_count", tok_count, exp_cnt);
        in_t = 4'h0;
        in_f = 4'h0;
        repeat (3) tick();
        check("partial_fall", in_a, 0);
        drain("partial");

        // Backpressure: four tokens fill the FIFO, the fifth waits
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = 4'(k);
            send(d, ~d, 1'b1, $sformatf("bp%0d", k));
        end
        in_t = 4'b0100;
        in_f = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("bp_hold%0d", i), in_a, 0);
        end
        check("bp_hold_count", tok_count, exp_cnt);
        check("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_after_pop", in_a, 0);
        tick();
        check("bp_fifth_ack", in_a, 1);
        exp_q.push_back(4'b0100);
        exp_cnt = exp_cnt + 16'd1;
        check("bp_fifth_count", tok_count, exp_cnt);
        in_t = 4'h0;
        in_f = 4'h0;
        repeat (3) tick();
        check("bp_fifth_fall", in_a, 0);
        out_ready = 1'b1;
        drain("bp");

        // Illegal code on bit 2
        in_t = 4'b1110;
        in_f = 4'b0101;
        repeat (4) tick();
        check("ill_err", err, 1);
        check("ill_in_a", in_a, 0);
        check("ill_count", tok_count, exp_cnt);
        check("ill_valid", out_valid, 0);
        in_t = 4'h0;
        in_f = 4'h0;
        repeat (4) tick();
        check("ill_err_sticky", err, 1);
        send(4'b0011, 4'b1100, 1'b1, "post_ill");
        check("ill_err_still", err, 1);
        drain("ill");

        // Reset in the middle of a handshake with the code held
        out_ready = 1'b0;
        in_t = 4'b1100;
        in_f = 4'b0011;
        repeat (3) tick();
        check("mid_ack", in_a, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_in_a", in_a, 0);
        check("mid_rst_count", tok_count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_err", err, 0);
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("mid_ignore%0d", i), in_a, 0);
        end
        check("mid_ignore_count", tok_count, 0);
        in_t = 4'h0;
        in_f = 4'h0;
        repeat (4) tick();
        send(4'b1100, 4'b0011, 1'b1, "mid_resend");
        check("mid_resend_valid", out_valid, 1);
        check("mid_resend_data", out_data, 4'hC);
        out_ready = 1'b1;
        drain("mid");

        // Streaming with continuous ready
        for (int i = 0; i < 40; i++) begin
            d = 4'($urandom_range(0, 15));
            send(d, ~d, 1'b1, $sformatf("stream%0d", i));
        end
        drain("stream");

        // Counter wrap: jump near the top, then cross 16'hFFFF
        force dut.tok_count = 16'hFFFD;
        tick();
        release dut.tok_count;
        exp_cnt = 16'hFFFD;
        tick();
        for (int i = 0; i < 4; i++) begin
            d = 4'($urandom_range(0, 15));
            send(d, ~d, 1'b1, $sformatf("wrap%0d", i));
        end
        check("wrap_final", tok_count, 16'h0001);
        drain("wrap");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dualrail_chan_sink.md
DUALRAIL_CHAN_SINK -- requirements
Module: dualrail_chan_sink

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the number of dual-rail data bits per token (1..16).
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the receive FIFO entries (power of 2, 2..16).
REQ-003 The module SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_t, input, WIDTH: true rails of the channel, driven asynchronously from the prsim domain.
REQ-007 Port in_f, input, WIDTH: false rails of the channel, driven asynchronously from the prsim domain.
REQ-008 Port in_a, output, 1: four-phase acknowledge returned to the prsim domain.
REQ-009 Port out_data, output, WIDTH: FIFO head word.
REQ-010 Port out_valid, output, 1: FIFO non-empty.
REQ-011 Port out_ready, input, 1: consumer accepts head when out_valid && out_ready.
REQ-012 Port tok_count, output, 16: tokens accepted since reset.
REQ-013 Port err, output, 1: sticky illegal-code flag.

Function
REQ-014 in_t and in_f SHALL each pass through a 2-flop synchronizer; all decode uses the synchronized copies (st, sf).
REQ-015 Per bit i, valid_i = st[i] ^ sf[i]; illegal_i = st[i] & sf[i]; complete = all valid_i and no illegal_i; neutral = st and sf all zero.
REQ-016 FSM states: WAIT_DATA (in_a=0) and WAIT_NEUTRAL (in_a=1); in_a SHALL be a registered output.
REQ-017 In WAIT_DATA, when complete and the FIFO is not full, the block SHALL write st into the FIFO, increment tok_count, and enter WAIT_NEUTRAL on the same edge, so in_a rises one cycle after complete is seen.
REQ-018 In WAIT_DATA, when complete and the FIFO is full, the block SHALL hold in_a=0 with no write until space frees (backpressure).
REQ-019 A full FIFO SHALL block a write even when a pop occurs in the same cycle; the write occurs on the following cycle.
REQ-020 In WAIT_NEUTRAL, when neutral is seen, the block SHALL return to WAIT_DATA on the next edge (in_a falls).
REQ-021 Partial codes (some bits valid, none illegal) SHALL cause no action in either state.
REQ-022 Any illegal_i in any state SHALL set err=1 until reset; no token is written while any illegal_i is present.
REQ-023 The FIFO SHALL be first-word-fall-through: out_data equals the head entry whenever out_valid=1, and is don't-care otherwise.
REQ-024 A pop on out_valid && out_ready SHALL advance the head; simultaneous push and pop on a non-full, non-empty FIFO SHALL keep the occupancy unchanged.
REQ-025 tok_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-026 Pointers SHALL be log2(DEPTH)+1 bits wide; full and empty are derived from the MSB and lower-bit compare.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL clear the synchronizers, FIFO pointers, and tok_count, set err=0, set in_a=0, set out_valid=0, and set the FSM state to WAIT_DATA.
REQ-028 Reset asserted mid-handshake SHALL drop in_a to 0 on the next edge; after reset the block SHALL ignore the channel until it is seen neutral once.

Verification
REQ-029 Single token: WIDTH=4, drive in_t=4'b1010, in_f=4'b0101 -> in_a=1 exactly 3 cycles later; out_valid=1 with out_data=4'hA; tok_count=1. Then drive both rails to 0 -> in_a=0 3 cycles later.
REQ-030 Backpressure: out_ready=0, send 5 tokens 0..4 with DEPTH=4 -> 4 tokens are acked; the 5th holds in_a=0. Assert out_ready for 1 cycle -> the 5th is acked on the next cycle; draining gives 0,1,2,3,4 in order.
REQ-031 Illegal code: drive in_t[2]=in_f[2]=1 -> err=1 and stays 1; no write, tok_count unchanged, in_a=0.
REQ-032 Partial then complete: raise bits one per cycle -> no ack until the last bit is valid, then in_a=1 one cycle after the synchronized complete.
REQ-033 Reset mid-handshake: assert rst while in_a=1 -> in_a=0, tok_count=0, out_valid=0 the next cycle; a held complete code is not re-accepted until neutral is seen.
REQ-034 Wrap: preload the count by sending 65536 tokens with continuous out_ready=1 -> tok_count=0 and no FIFO overflow.
